// File: rtl/mux_8to1.sv
// ============================================================================
// Module   : mux_8to1
// Brief    : 8-to-1 lane selector with optional one-deep valid/select pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_8to1 #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*WIDTH-1:0]   in,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [2:0]           out_sel
);

    logic [WIDTH-1:0] w_lane [8];
    logic [WIDTH-1:0] w_sel_lane;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_lane
            assign w_lane[k] = in[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_sel_lane = w_lane[sel];

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] out_q, out_d;
            logic [2:0]       sel_q, sel_d;
            logic             valid_q, valid_d;

            // Data and select only move on a qualified edge; valid tracks every edge.
            always_comb begin
                out_d   = out_q;
                sel_d   = sel_q;
                valid_d = in_valid;
                if (in_valid) begin
                    out_d = w_sel_lane;
                    sel_d = sel;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q   <= '0;
                    sel_q   <= 3'd0;
                    valid_q <= 1'b0;
                end else begin
                    out_q   <= out_d;
                    sel_q   <= sel_d;
                    valid_q <= valid_d;
                end
            end

            assign out       = out_q;
            assign out_sel   = sel_q;
            assign out_valid = valid_q;
        end else begin : g_comb
            assign out       = w_sel_lane;
            assign out_sel   = sel;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mux_8to1.sv
// ============================================================================
// Module   : tb_mux_8to1
// Brief    : Self-checking bench: registered W=1, registered W=8, combinational W=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_8to1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  in1 = '0;
    logic [2:0]  sel1 = '0;
    logic        v1 = 1'b0;
    logic        out1, ov1;
    logic [2:0]  os1;

    logic [63:0] in8 = '0;
    logic [2:0]  sel8 = '0;
    logic        v8 = 1'b0;
    logic [7:0]  out8;
    logic        ov8;
    logic [2:0]  os8;

    logic [7:0]  inc = '0;
    logic [2:0]  selc = '0;
    logic        vc = 1'b0;
    logic        outc, ovc;
    logic [2:0]  osc;

    int n_vec = 0;
    int n_err = 0;

    // Reference state for the registered instances
    logic        e1;
    logic        ev1;
    logic [2:0]  es1;
    logic [7:0]  e8;
    logic        ev8;
    logic [2:0]  es8;

    always #5 clk = ~clk;

    mux_8to1 #(.WIDTH(1), .REGISTERED(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in(in1), .sel(sel1), .in_valid(v1),
        .out(out1), .out_valid(ov1), .out_sel(os1)
    );

    mux_8to1 #(.WIDTH(8), .REGISTERED(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .in(in8), .sel(sel8), .in_valid(v8),
        .out(out8), .out_valid(ov8), .out_sel(os8)
    );

    mux_8to1 #(.WIDTH(1), .REGISTERED(1'b0)) u_comb (
        .clk(clk), .rst(rst), .in(inc), .sel(selc), .in_valid(vc),
        .out(outc), .out_valid(ovc), .out_sel(osc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e1 = 1'b0; ev1 = 1'b0; es1 = 3'd0;
        e8 = 8'h00; ev8 = 1'b0; es8 = 3'd0;
    endtask

    // Advance one clock, update the reference from the inputs that were sampled, then check.
    task automatic tick();
        logic [63:0] sh;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            ev1 = v1;
            if (v1) begin
                e1  = in1[sel1];
                es1 = sel1;
            end
            ev8 = v8;
            if (v8) begin
                sh  = in8 >> (int'(sel8) * 8);
                e8  = sh[7:0];
                es8 = sel8;
            end
        end
        #1;
        check("w1_out",   64'(out1), 64'(e1));
        check("w1_valid", 64'(ov1),  64'(ev1));
        check("w1_sel",   64'(os1),  64'(es1));
        check("w8_out",   64'(out8), 64'(e8));
        check("w8_valid", 64'(ov8),  64'(ev8));
        check("w8_sel",   64'(os8),  64'(es8));
    endtask

    task automatic check_now(input string tag);
        check({tag, "_w1_out"},   64'(out1), 64'(e1));
        check({tag, "_w1_valid"}, 64'(ov1),  64'(ev1));
        check({tag, "_w1_sel"},   64'(os1),  64'(es1));
        check({tag, "_w8_out"},   64'(out8), 64'(e8));
        check({tag, "_w8_valid"}, 64'(ov8),  64'(ev8));
        check({tag, "_w8_sel"},   64'(os8),  64'(es8));
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_now("reset");

        // Capture a 1, then hit it with an asynchronous reset mid-cycle
        @(negedge clk);
        rst = 1'b0;
        v1 = 1'b1; in1 = 8'hFF; sel1 = 3'd0;
        tick();
        check("pre_reset_out1", 64'(out1), 64'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_now("async_reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_reset_out1", 64'(out1), 64'd1);

        // Pattern A sweep
        in1 = 8'b1010_1010;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            sel1 = 3'(s);
            tick();
            check("patA_out", 64'(out1), 64'(s & 1));
        end

        // Pattern B sweep, new data arriving together with sel=7
        @(negedge clk);
        in1 = 8'b1100_1100; sel1 = 3'd7;
        tick();
        check("patB_sel7", 64'(out1), 64'd1);
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            sel1 = 3'(s);
            tick();
        end

        // Hold when in_valid drops
        @(negedge clk);
        in1 = 8'hAA; sel1 = 3'd1; v1 = 1'b1;
        tick();
        @(negedge clk);
        v1 = 1'b0; in1 = 8'h00; sel1 = 3'd2;
        tick();
        check("hold_out",   64'(out1), 64'd1);
        check("hold_sel",   64'(os1),  64'd1);
        check("hold_valid", 64'(ov1),  64'd0);

        // Wide lanes: lane k = 0x10+k, select 5, then disturb the other lanes
        @(negedge clk);
        for (int k = 0; k < 8; k++) in8[k*8 +: 8] = 8'(8'h10 + k);
        sel8 = 3'd5; v8 = 1'b1;
        tick();
        check("wide_out", 64'(out8), 64'h15);
        @(negedge clk);
        in8 = in8 ^ ~(64'hFF << 40);
        tick();
        check("wide_isolate", 64'(out8), 64'h15);

        // Mid-cycle input changes must not reach the registered output
        @(negedge clk);
        v8 = 1'b0; v1 = 1'b0;
        tick();
        #2 in8 = ~in8; sel8 = 3'd2; in1 = ~in1;
        #1;
        check_now("between_edges");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in1  = 8'($urandom);
            sel1 = 3'($urandom);
            v1   = 1'($urandom_range(0, 3) != 0);
            in8  = {$urandom, $urandom};
            sel8 = 3'($urandom);
            v8   = 1'($urandom_range(0, 3) != 0);
            if (i == 150) begin
                #1 rst = 1'b1;
                #1 model_reset();
                check_now("rand_async_reset");
                tick();
                @(negedge clk);
                rst = 1'b0;
            end
            tick();
        end

        // Combinational build
        inc = 8'b1100_1100; selc = 3'd3; vc = 1'b1;
        #1;
        check("comb_out",   64'(outc), 64'd1);
        check("comb_sel",   64'(osc),  64'd3);
        check("comb_valid", 64'(ovc),  64'd1);
        selc = 3'd4;
        #1;
        check("comb_out_sel4", 64'(outc), 64'd0);
        for (int i = 0; i < 100; i++) begin
            inc  = 8'($urandom);
            selc = 3'($urandom);
            vc   = 1'($urandom);
            #1;
            check("comb_rand_out",   64'(outc), 64'((inc >> selc) & 8'h01));
            check("comb_rand_sel",   64'(osc),  64'(selc));
            check("comb_rand_valid", 64'(ovc),  64'(vc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_8to1.md
# mux_8to1

Registered 8-to-1 lane selector: picks one of eight equal-width lanes from a packed input bus under a 3-bit select and presents it on a single output lane. Used wherever a datapath must route one of eight sources to a common sink. It carries a one-deep valid/select pipeline so downstream logic knows when the output is fresh and which lane it came from.

## Interface

Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- WIDTH, default 1, bit width of each lane; legal range 1..64.
- REGISTERED, default 1; 1 = output registered (1-cycle latency), 0 = purely combinational path with no registers.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  8*WIDTH  packed lanes; lane k occupies in[k*WIDTH +: WIDTH]; lane 0 is the LSBs.
- sel  input  3  lane index 0..7.
- in_valid  input  1  qualifies in/sel for capture.
- out  output  WIDTH  selected lane.
- out_valid  output  1  out holds a lane captured on the previous qualified edge.
- out_sel  output  3  sel value that produced the current out.

## Operation

- Selection: out gets lane in[sel*WIDTH +: WIDTH]. All 8 sel codes are legal; there is no default or invalid case.
- REGISTERED=1:
  - On a rising clk edge with in_valid=1: out <= selected lane, out_sel <= sel, out_valid <= 1.
  - On a rising edge with in_valid=0: out and out_sel hold their values; out_valid <= 0.
- REGISTERED=0:
  - out = selected lane, combinational.
  - out_sel = sel.
  - out_valid = in_valid.
  - clk and rst are unused; no registers are inferred.
- Bit order within a lane is preserved, with no reversal or sign extension.
- The output depends only on the selected lane. Changes on any other lane never affect out.

## Timing

- Reset (REGISTERED=1): rst high clears out=0, out_sel=0, out_valid=0 immediately, without waiting for a clock edge. The values hold while rst is high. The first capture happens on the first rising edge after rst deasserts.
- Reset mid-stream: any captured value is discarded. out_valid drops within the same cycle that rst asserts.
- Reset has priority over in_valid when both are high at a clock edge.
- Latency (REGISTERED=1): exactly 1 cycle from the edge that samples in/sel/in_valid to out, out_sel and out_valid.
- Throughput: one selection per cycle. Back-to-back in_valid gives a new out every cycle.
- Latency (REGISTERED=0): zero cycles, combinational only.
- A sel or in change between edges has no effect on out until the next qualified edge (REGISTERED=1).

## Test plan

- Reset: assert rst asynchronously mid-cycle while out=1 and out_valid=1 -> out=0, out_sel=0, out_valid=0 before the next edge. Deassert rst, then apply in_valid=1, in=8'hFF, sel=0 -> out=1 one cycle later.
- Pattern A sweep (WIDTH=1): in=8'b10101010, in_valid=1, sel stepping 0..7 one per cycle -> out=0,1,0,1,0,1,0,1, each one cycle after its sel. out_sel tracks sel with 1-cycle lag. out_valid stays 1.
- Pattern B sweep (WIDTH=1): in=8'b11001100 applied in the same cycle as sel=7, then sel stepping 0..7 -> out=1 for the sel=7 sample, followed by 0,0,1,1,0,0,1,1.
- Hold: capture in=8'hAA with sel=1 (out=1), then drop in_valid and change in=8'h00, sel=2 -> out stays 1, out_sel stays 1, out_valid=0.
- Wide lanes (WIDTH=8): lane k = 8'h10+k, sel=5 -> out=8'h15. Then toggle every non-selected lane -> out unchanged at 8'h15.
- Combinational build (REGISTERED=0): in=8'b11001100, sel=3, in_valid=1 -> out=1, out_sel=3, out_valid=1 within the same cycle with no clock. Change sel to 4 -> out=0 immediately.
